// File: rtl/polirv_pkg.sv
// Shared definitions for the polirv instruction-memory loader:
// state encodings, header width and byte-lane constants.
package polirv_pkg;

    localparam int HDR_W  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR0 = 3'd1;
    localparam logic [2:0] S_HDR1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_HDR0 = S_HDR0,
        ST_HDR1 = S_HDR1,
        ST_DATA = S_DATA,
        ST_CHK  = S_CHK,
        ST_RUN  = S_RUN,
        ST_ERR  = S_ERR
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Word RAM with an asynchronous read port and a synchronous write port.
// No reset: contents are undefined until written.
module imem_array #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_BITS];

    // Write one word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader/responder for the polirv core.
// Fills a word RAM from a byte-serial valid/ready stream (count header,
// little-endian words) and holds the core in reset until the image is in.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import polirv_pkg::*;
#(
    parameter int i_addr_bits = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [WORD_W-1:0]      i_mem_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [BYTE_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   core_rst_n,
    output logic                   ld_done,
    output logic                   ld_err
);

    localparam logic [HDR_W-1:0] DEPTH = HDR_W'(2**i_addr_bits);

    state_t                 r_state;
    state_t                 w_next;
    logic [HDR_W-1:0]       r_count;
    logic [i_addr_bits:0]   r_wptr;
    logic [1:0]             r_lane;
    logic [23:0]            r_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]      r_sum;
`endif
    logic                   r_ready;
    logic                   r_core_rst_n;
    logic                   r_done;
    logic                   r_err;
    logic                   w_ready;
    logic                   w_core_rst_n;
    logic                   w_done;
    logic                   w_err;

    logic                   w_xfer;
    logic [HDR_W-1:0]       w_count;
    logic                   w_count_ok;
    logic                   w_last_word;
    logic                   w_we;

    // A restart pulse wins over a byte offered in the same cycle
    assign w_xfer      = ld_valid && r_ready && !ld_start;
    assign w_count     = {ld_data, r_count[BYTE_W-1:0]};
    assign w_count_ok  = (w_count != '0) && (w_count <= DEPTH);
    assign w_last_word = (HDR_W'(r_wptr) + HDR_W'(1)) == r_count;
    assign w_we        = w_xfer && (r_state == ST_DATA) && (r_lane == LANE3);

    // Next-state selection and decode of the registered status outputs
    always_comb begin
        w_next = r_state;
        if (ld_start) begin
            w_next = ST_HDR0;
        end else if (w_xfer) begin
            case (r_state)
                ST_HDR0: w_next = ST_HDR1;
                ST_HDR1: w_next = w_count_ok ? ST_DATA : ST_ERR;
                ST_DATA: begin
                    if ((r_lane == LANE3) && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next = ST_CHK;
`else
                        w_next = ST_RUN;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK:  w_next = (ld_data == r_sum) ? ST_RUN : ST_ERR;
`endif
                default: w_next = r_state;
            endcase
        end
        w_ready      = (w_next == ST_HDR0) || (w_next == ST_HDR1) ||
                       (w_next == ST_DATA) || (w_next == ST_CHK);
        w_core_rst_n = (w_next == ST_RUN);
        w_done       = (w_next == ST_RUN);
        w_err        = (w_next == ST_ERR);
    end

    // State and status registers; outputs change on the edge entering a state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_ready      <= w_ready;
            r_core_rst_n <= w_core_rst_n;
            r_done       <= w_done;
            r_err        <= w_err;
        end
    end

    // Header capture, word assembly, write pointer and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_lane  <= LANE0;
            r_hold  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else if (ld_start) begin
            r_wptr  <= '0;
            r_lane  <= LANE0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (r_state != ST_CHK) begin
                r_sum <= r_sum + ld_data;
            end
`endif
            case (r_state)
                ST_HDR0: r_count[BYTE_W-1:0] <= ld_data;
                ST_HDR1: r_count <= w_count;
                ST_DATA: begin
                    r_lane <= r_lane + 2'd1;
                    case (r_lane)
                        LANE0:   r_hold[7:0]   <= ld_data;
                        LANE1:   r_hold[15:8]  <= ld_data;
                        LANE2:   r_hold[23:16] <= ld_data;
                        default: r_wptr <= r_wptr + (i_addr_bits+1)'(1);
                    endcase
                end
                default: ;
            endcase
        end
    end

    imem_array #(
        .ADDR_BITS (i_addr_bits),
        .DATA_W    (WORD_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wptr[i_addr_bits-1:0]),
        .wdata ({ld_data, r_hold}),
        .raddr (i_mem_addr),
        .rdata (i_mem_data)
    );

    assign ld_ready   = r_ready;
    assign core_rst_n = r_core_rst_n;
    assign ld_done    = r_done;
    assign ld_err     = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios, hand-written
// restart/reset sequences and randomized loads against an image-level model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

   localparam int AW = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] i_mem_addr;
   logic [31:0]   i_mem_data;
   logic          ld_start;
   logic          ld_valid;
   logic [7:0]    ld_data;
   logic          ld_ready;
   logic          core_rst_n;
   logic          ld_done;
   logic          ld_err;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [31:0] refMem   [64];
   bit          refKnown [64];
   logic [31:0] imgWords [$];

   typedef struct {
      string       name;
      logic [15:0] count;
      int          gapMode;
      bit          badSum;
      bit          expDone;
      bit          expErr;
   } vec_t;

   vec_t vecs [7];

   imem_loader #(.i_addr_bits(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_mem_addr (i_mem_addr),
      .i_mem_data (i_mem_data),
      .ld_start   (ld_start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .core_rst_n (core_rst_n),
      .ld_done    (ld_done),
      .ld_err     (ld_err)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one byte; gapMode 1 idles a cycle first, 2 idles at random
   task automatic applyStimulus(input logic [7:0] b, input int gapMode);
      if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1)) begin
         ld_valid = 1'b0;
         ld_data  = 8'($urandom);
         tick();
      end
      ld_valid = 1'b1;
      ld_data  = b;
      tick();
      ld_valid = 1'b0;
      ld_data  = 8'($urandom);
   endtask

   task automatic pulseStart();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic fillRandomWords(input int n);
      imgWords.delete();
      for (int i = 0; i < n; i++) imgWords.push_back($urandom);
   endtask

   task automatic verifyMem(input string tag);
      for (int a = 0; a < 64; a++) begin
         if (refKnown[a]) begin
            i_mem_addr = AW'(a);
            #1;
            checkOutput($sformatf("%s mem[%0d]", tag, a), i_mem_data, refMem[a]);
         end
      end
   endtask

   // Stream a whole image built from the count and imgWords; the model
   // decides acceptance purely from the count range and the byte sum
   task automatic loadImage(input string tag, input logic [15:0] n, input int gapMode,
                            input bit badSum, input bit expDone, input bit expErr,
                            input bit doStart);
      logic [7:0] q [$];
      logic [7:0] sum;
      bit         countOk;
      countOk = (n >= 16'd1) && (n <= 16'd64);
      q.push_back(n[7:0]);
      q.push_back(n[15:8]);
      if (countOk) begin
         for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) q.push_back(imgWords[i][8*k +: 8]);
         end
         if (CHK_ON) begin
            sum = 8'd0;
            foreach (q[i]) sum = sum + q[i];
            q.push_back(badSum ? sum + 8'd1 : sum);
         end
      end
      if (doStart) pulseStart();
      for (int i = 0; i < q.size() - 1; i++) applyStimulus(q[i], gapMode);
      checkOutput({tag, " ready mid"}, 32'(ld_ready), 32'd1);
      checkOutput({tag, " core_rst_n mid"}, 32'(core_rst_n), 32'd0);
      applyStimulus(q[q.size() - 1], gapMode);
      checkOutput({tag, " done"}, 32'(ld_done), 32'(expDone));
      checkOutput({tag, " err"}, 32'(ld_err), 32'(expErr));
      checkOutput({tag, " core_rst_n"}, 32'(core_rst_n), 32'(expDone));
      checkOutput({tag, " ready end"}, 32'(ld_ready), 32'd0);
      if (countOk) begin
         for (int i = 0; i < int'(n); i++) begin
            refMem[i]   = imgWords[i];
            refKnown[i] = 1'b1;
         end
      end
      verifyMem(tag);
   endtask

   initial begin
      logic [31:0] partial;
      logic [15:0] rn;
      bit          rBad;
      bit          rOk;

      vecs[0] = '{"n1",      16'd1,      0, 1'b0, 1'b1,    1'b0};
      vecs[1] = '{"n0",      16'd0,      0, 1'b0, 1'b0,    1'b1};
      vecs[2] = '{"n65",     16'd65,     0, 1'b0, 1'b0,    1'b1};
      vecs[3] = '{"n64",     16'd64,     2, 1'b0, 1'b1,    1'b0};
      vecs[4] = '{"n320",    16'h0140,   0, 1'b0, 1'b0,    1'b1};
      vecs[5] = '{"n8002",   16'h8002,   1, 1'b0, 1'b0,    1'b1};
      vecs[6] = '{"badsum",  16'd3,      1, 1'b1, !CHK_ON, CHK_ON};

      foreach (refKnown[i]) refKnown[i] = 1'b0;
      rst_n      = 1'b0;
      ld_start   = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = 8'h00;
      i_mem_addr = '0;

      // Reset state
      tick();
      tick();
      checkOutput("rst ready", 32'(ld_ready), 32'd0);
      checkOutput("rst core_rst_n", 32'(core_rst_n), 32'd0);
      checkOutput("rst done", 32'(ld_done), 32'd0);
      checkOutput("rst err", 32'(ld_err), 32'd0);
      rst_n = 1'b1;
      applyStimulus(8'h02, 0);
      checkOutput("idle ignores bytes", 32'(ld_ready), 32'd0);

      // Nominal two-word image from the board program
      imgWords = '{32'h00500093, 32'h00000013};
      loadImage("nominal", 16'd2, 0, 1'b0, 1'b1, 1'b0, 1'b1);
`ifndef IMEM_LOADER_CHECKSUM_EN
      applyStimulus(8'hAA, 0);
      checkOutput("extra byte done", 32'(ld_done), 32'd1);
      checkOutput("extra byte ready", 32'(ld_ready), 32'd0);
`endif

      // Start while running drops core reset on the next edge
      pulseStart();
      checkOutput("run restart core_rst_n", 32'(core_rst_n), 32'd0);
      checkOutput("run restart done", 32'(ld_done), 32'd0);
      checkOutput("run restart ready", 32'(ld_ready), 32'd1);

      // Start coincident with a byte: that byte (0x05) must be dropped
      ld_start = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 8'h05;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b0;
      fillRandomWords(1);
      loadImage("coincident", 16'd1, 0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Restart mid-data after a partial word and after one full word
      for (int k = 3; k <= 5; k += 2) begin
         fillRandomWords(2);
         pulseStart();
         applyStimulus(8'h02, 0);
         applyStimulus(8'h00, 0);
         partial = $urandom;
         for (int b = 0; b < k; b++) applyStimulus(partial[8*(b%4) +: 8], 0);
         if (k >= 4) begin
            refMem[0]   = partial;
            refKnown[0] = 1'b1;
         end
         pulseStart();
         checkOutput($sformatf("restart%0d ready", k), 32'(ld_ready), 32'd1);
         checkOutput($sformatf("restart%0d done", k), 32'(ld_done), 32'd0);
         loadImage($sformatf("reload%0d", k), 16'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      end

      // Table of count and checksum scenarios
      for (int v = 0; v < 7; v++) begin
         fillRandomWords(64);
         loadImage(vecs[v].name, vecs[v].count, vecs[v].gapMode, vecs[v].badSum,
                   vecs[v].expDone, vecs[v].expErr, 1'b1);
      end

      // Randomized loads judged by the count-range and checksum rules
      for (int r = 0; r < 6; r++) begin
         rn   = 16'($urandom_range(1, 12));
         if ($urandom_range(0, 4) == 0) rn = 16'($urandom_range(65, 2000));
         rBad = ($urandom_range(0, 3) == 0);
         rOk  = (rn >= 16'd1) && (rn <= 16'd64);
         fillRandomWords(64);
         loadImage($sformatf("rand%0d", r), rn, 2, rBad,
                   rOk && !(CHK_ON && rBad), !(rOk && !(CHK_ON && rBad)), 1'b1);
      end

      // Gapped reload of the nominal image, valid low every other cycle
      imgWords = '{32'h00500093, 32'h00000013};
      loadImage("gapped", 16'd2, 1, 1'b0, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a load
      fillRandomWords(4);
      pulseStart();
      applyStimulus(8'h04, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h11, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async ready", 32'(ld_ready), 32'd0);
      checkOutput("async core_rst_n", 32'(core_rst_n), 32'd0);
      checkOutput("async done", 32'(ld_done), 32'd0);
      checkOutput("async err", 32'(ld_err), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("after async ready", 32'(ld_ready), 32'd0);
      loadImage("post reset", 16'd4, 0, 1'b0, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
